// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the half-duplex bus engine.
package bidir_bus_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_TA_OUT = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_TA_IN  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/bidir_bus_engine_if.sv
// Control and status bundle between the bus engine and its host logic.
interface bidir_bus_engine_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 En;
  logic [1:0]           Mode;
  logic                 Dir;
  logic                 Done_Sig;
  logic [CNT_WIDTH-1:0] Frame_Cnt;

  modport master (input En, input Mode, output Dir, output Done_Sig, output Frame_Cnt);
  modport slave  (output En, output Mode, input Dir, input Done_Sig, input Frame_Cnt);
endinterface

// File: rtl/bus_phase_counter.sv
// Loadable down-counter that times each FSM phase; zero marks the phase's last cycle.
module bus_phase_counter
  import bidir_bus_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic [PHASE_W-1:0] count,
  output logic               zero
);

  logic [PHASE_W-1:0] count_r;

  // Reload on phase entry, otherwise count down and rest at zero
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_r <= {PHASE_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {PHASE_W{1'b0}}) begin
      count_r <= count_r - PHASE_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {PHASE_W{1'b0}});

endmodule

// File: rtl/bidir_bus_engine.sv
// Half-duplex engine: samples the shared bus, transforms the value and drives it back
// between programmable hi-Z turnaround gaps.
module bidir_bus_engine
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int TURN_CYC  = 1,
  parameter int DRIVE_CYC = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  inout  wire  [WIDTH-1:0]   Data,
  output logic               ext_clk,
  bidir_bus_engine_if.master bus
);

  localparam bit                 HAS_TURN   = (TURN_CYC > 0);
  localparam logic [PHASE_W-1:0] TURN_LOAD  = HAS_TURN ? PHASE_W'(TURN_CYC - 1) : {PHASE_W{1'b0}};
  localparam logic [PHASE_W-1:0] DRIVE_LOAD = PHASE_W'(DRIVE_CYC - 1);

  state_e               state_r, next_s;
  logic [WIDTH-1:0]     rdata_r;
  logic [1:0]           mode_r, mode_s;
  logic                 dir_r, oe_r, done_r, done_next_s;
  logic [CNT_WIDTH-1:0] frame_cnt_r;
  logic [PHASE_W-1:0]   load_val_s, phase_cnt_s;
  logic                 zero_s;

  function automatic logic [WIDTH-1:0] transform(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       m,
                                                 input logic [WIDTH-1:0] prev);
    case (m)
      MODE_PASS: transform = d;
      MODE_INV:  transform = ~d;
      MODE_INC:  transform = d + WIDTH'(1);
      MODE_HOLD: transform = prev;
      default:   transform = prev;
    endcase
  endfunction

  bus_phase_counter u_phase (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (zero_s),
    .load_val (load_val_s),
    .count    (phase_cnt_s),
    .zero     (zero_s)
  );

  // Next-state decode, phase length of the state being entered, and Done look-ahead
  always_comb begin
    next_s      = state_r;
    load_val_s  = {PHASE_W{1'b0}};
    done_next_s = 1'b0;
    case (state_r)
      ST_IDLE:   if (bus.En) next_s = ST_SAMPLE; else next_s = ST_IDLE;
      ST_SAMPLE: if (HAS_TURN) next_s = ST_TA_OUT; else next_s = ST_DRIVE;
      ST_TA_OUT: if (zero_s) next_s = ST_DRIVE; else next_s = ST_TA_OUT;
      ST_DRIVE: begin
        if (!zero_s)      next_s = ST_DRIVE;
        else if (HAS_TURN) next_s = ST_TA_IN;
        else if (bus.En)   next_s = ST_SAMPLE;
        else               next_s = ST_IDLE;
      end
      ST_TA_IN: begin
        if (!zero_s)     next_s = ST_TA_IN;
        else if (bus.En) next_s = ST_SAMPLE;
        else             next_s = ST_IDLE;
      end
      default: next_s = ST_IDLE;
    endcase
    case (next_s)
      ST_TA_OUT, ST_TA_IN: load_val_s = TURN_LOAD;
      ST_DRIVE:            load_val_s = DRIVE_LOAD;
      default:             load_val_s = {PHASE_W{1'b0}};
    endcase
    // Done must be high in the cycle whose phase count will read zero while driving
    if (next_s == ST_DRIVE) begin
      if (zero_s) done_next_s = (DRIVE_LOAD == {PHASE_W{1'b0}});
      else        done_next_s = (phase_cnt_s == PHASE_W'(1));
    end else begin
      done_next_s = 1'b0;
    end
  end

  // Mode in force: the live input during SAMPLE, the latched copy otherwise
  always_comb begin
    if (state_r == ST_SAMPLE) mode_s = bus.Mode;
    else                      mode_s = mode_r;
  end

  // State register, capture at end of SAMPLE, and registered bus outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= ST_IDLE;
      rdata_r     <= {WIDTH{1'b0}};
      mode_r      <= MODE_PASS;
      dir_r       <= 1'b0;
      oe_r        <= 1'b0;
      done_r      <= 1'b0;
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_s;
      dir_r   <= (next_s == ST_DRIVE);
      oe_r    <= (next_s == ST_DRIVE);
      done_r  <= done_next_s;
      if (state_r == ST_SAMPLE) begin
        mode_r  <= mode_s;
        rdata_r <= transform(Data, mode_s, rdata_r);
      end
      if (done_r) frame_cnt_r <= frame_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign Data          = oe_r ? rdata_r : {WIDTH{1'bz}};
  assign ext_clk       = CLK;
  assign bus.Dir       = dir_r;
  assign bus.Done_Sig  = done_r;
  assign bus.Frame_Cnt = frame_cnt_r;

endmodule
